// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types and default widths
package calc_pkg;

    localparam int CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add sequential multiplier, one multiplier bit per cycle (SEQ_MULT_SIGNED_EN selects two's complement)
module seq_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]           state;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [2*WIDTH-1:0]   mcand_ext;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    // Partial product for the current bit and the next accumulator value.
    // The multiplier register shifts right each cycle, so bit 0 is always
    // the bit whose weight equals the counter.
    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        mcand_ext = {{WIDTH{mcand_q[WIDTH-1]}}, mcand_q};
`else
        mcand_ext = {{WIDTH{1'b0}}, mcand_q};
`endif
        partial   = mcand_ext << cnt_q;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        acc_next  = acc_q;
        if (mplier_q[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
            // The sign bit of a two's complement multiplier carries negative weight.
            if (last_iter) begin
                acc_next = acc_q - partial;
            end else begin
                acc_next = acc_q + partial;
            end
`else
            acc_next = acc_q + partial;
`endif
        end
    end

    // FSM and datapath registers; a start outside IDLE is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            product  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand_q  <= multiplicand;
                        mplier_q <= multiplier;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        product <= acc_next;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
